// File: rtl/stack_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// stack_cpu_ctrl
//
// Multi-cycle control unit for the 16-bit stack-machine datapath. Latches the
// fetched instruction into ir, sequences FETCH/EX1/EX2/HALT and generates every
// datapath strobe. Branch condition evaluation stays in the datapath; this
// block only selects the conditional incrementer mode via pci.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous, active-low reset
//   instr_in  instruction word from instruction memory at current PC
//   ir        latched instruction register (drives datapath isr)
//   regw      register-bank write
//   memw      stack-memory write at mem[SP]
//   memin     memory data select: 0 = reg x, 1 = PC, 2 = sign-extended imm
//   sflag     flag register update
//   spi       SP next value: 0 = hold, 1 = SP+1, 2 = SP-1
//   spw       SP write enable
//   pcin      PC source: 0 = mem[SP], 1 = incrementer
//   pci       incrementer mode: 0 = PC+1, 1 = PC+1+imm if cc
//   pcw       PC write enable
//   halted    high in HALT state
// -----------------------------------------------------------------------------
module stack_cpu_ctrl #(
   parameter logic [15:0] IR_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr_in,
   output logic [15:0] ir,
   output logic        regw,
   output logic        memw,
   output logic [1:0]  memin,
   output logic        sflag,
   output logic [1:0]  spi,
   output logic        spw,
   output logic        pcin,
   output logic        pci,
   output logic        pcw,
   output logic        halted
);

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_EX1,
      ST_EX2,
      ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_ALU,
      OP_PUSH_REG,
      OP_POP,
      OP_PUSH_IMM,
      OP_BRANCH,
      OP_CALL,
      OP_RET,
      OP_HALT,
      OP_NOP
   } op_t;

   typedef struct packed {
      logic       regw;
      logic       memw;
      logic [1:0] memin;
      logic       sflag;
      logic [1:0] spi;
      logic       spw;
      logic       pcin;
      logic       pci;
      logic       pcw;
      logic       halted;
   } ctrl_t;

   state_t      state_q;
   state_t      state_nxt;
   logic [15:0] ir_q;
   logic [15:0] ir_nxt;
   op_t         op_nxt;
   ctrl_t       ctrl_q;
   ctrl_t       ctrl_nxt;

   // ir only moves in FETCH; everywhere else instr_in is ignored.
   always_comb begin
      ir_nxt = ir_q;
      if (state_q == ST_FETCH) begin
         ir_nxt = instr_in;
      end
   end

   // Decode of the instruction that will be held in the next state. Outside
   // FETCH this equals the current ir, so the same decode drives both the
   // state transition out of EX1 and the registered strobes.
   always_comb begin
      op_nxt = OP_NOP;
      case (ir_nxt[15:14])
         2'b00: begin
            if (ir_nxt[13:11] != 3'b000) begin
               op_nxt = OP_ALU;
            end
         end
         2'b01: begin
            case (ir_nxt[7:5])
               3'b000:  op_nxt = OP_PUSH_REG;
               3'b001:  op_nxt = OP_POP;
               3'b010:  op_nxt = OP_PUSH_IMM;
               default: op_nxt = OP_NOP;
            endcase
         end
         2'b10: begin
            op_nxt = OP_BRANCH;
         end
         default: begin
            case (ir_nxt[13:12])
               2'b00:   op_nxt = OP_CALL;
               2'b01:   op_nxt = OP_RET;
               2'b10:   op_nxt = OP_HALT;
               default: op_nxt = OP_NOP;
            endcase
         end
      endcase
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_FETCH: state_nxt = ST_EX1;
         ST_EX1: begin
            case (op_nxt)
               OP_PUSH_REG,
               OP_PUSH_IMM,
               OP_CALL,
               OP_RET:  state_nxt = ST_EX2;
               OP_HALT: state_nxt = ST_HALT;
               default: state_nxt = ST_FETCH;
            endcase
         end
         ST_EX2:  state_nxt = ST_FETCH;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_FETCH;
      endcase
   end

   // Strobes are computed for the state being entered and registered with it,
   // so they are Moore outputs of (state, ir) with no combinational path.
   always_comb begin
      ctrl_nxt = '0;
      case (state_nxt)
         ST_EX1: begin
            case (op_nxt)
               OP_ALU: begin
                  ctrl_nxt.regw  = 1'b1;
                  ctrl_nxt.sflag = 1'b1;
                  ctrl_nxt.pcw   = 1'b1;
                  ctrl_nxt.pcin  = 1'b1;
               end
               OP_PUSH_REG,
               OP_PUSH_IMM,
               OP_CALL: begin
                  ctrl_nxt.spw = 1'b1;
                  ctrl_nxt.spi = 2'd2;
               end
               OP_POP: begin
                  ctrl_nxt.regw = 1'b1;
                  ctrl_nxt.spw  = 1'b1;
                  ctrl_nxt.spi  = 2'd1;
                  ctrl_nxt.pcw  = 1'b1;
                  ctrl_nxt.pcin = 1'b1;
               end
               OP_BRANCH: begin
                  ctrl_nxt.pcw  = 1'b1;
                  ctrl_nxt.pcin = 1'b1;
                  ctrl_nxt.pci  = 1'b1;
               end
               OP_RET: begin
                  // PC <= mem[SP]; memw stays low so mem and PC-from-mem never overlap.
                  ctrl_nxt.pcw  = 1'b1;
                  ctrl_nxt.pcin = 1'b0;
               end
               OP_HALT: begin
                  ctrl_nxt = '0;
               end
               default: begin
                  ctrl_nxt.pcw  = 1'b1;
                  ctrl_nxt.pcin = 1'b1;
               end
            endcase
         end
         ST_EX2: begin
            case (op_nxt)
               OP_PUSH_REG: begin
                  ctrl_nxt.memw  = 1'b1;
                  ctrl_nxt.memin = 2'd0;
                  ctrl_nxt.pcw   = 1'b1;
                  ctrl_nxt.pcin  = 1'b1;
               end
               OP_PUSH_IMM: begin
                  ctrl_nxt.memw  = 1'b1;
                  ctrl_nxt.memin = 2'd2;
                  ctrl_nxt.pcw   = 1'b1;
                  ctrl_nxt.pcin  = 1'b1;
               end
               OP_CALL: begin
                  // Stores the CALL's own PC, then jumps PC+1+imm.
                  ctrl_nxt.memw  = 1'b1;
                  ctrl_nxt.memin = 2'd1;
                  ctrl_nxt.pcw   = 1'b1;
                  ctrl_nxt.pcin  = 1'b1;
                  ctrl_nxt.pci   = 1'b1;
               end
               OP_RET: begin
                  // Resume after the CALL and pop the return slot together.
                  ctrl_nxt.pcw  = 1'b1;
                  ctrl_nxt.pcin = 1'b1;
                  ctrl_nxt.spw  = 1'b1;
                  ctrl_nxt.spi  = 2'd1;
               end
               default: begin
                  ctrl_nxt = '0;
               end
            endcase
         end
         ST_HALT: begin
            ctrl_nxt.halted = 1'b1;
         end
         default: begin
            ctrl_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         ir_q    <= IR_RESET;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_nxt;
         ir_q    <= ir_nxt;
         ctrl_q  <= ctrl_nxt;
      end
   end

   assign ir     = ir_q;
   assign regw   = ctrl_q.regw;
   assign memw   = ctrl_q.memw;
   assign memin  = ctrl_q.memin;
   assign sflag  = ctrl_q.sflag;
   assign spi    = ctrl_q.spi;
   assign spw    = ctrl_q.spw;
   assign pcin   = ctrl_q.pcin;
   assign pci    = ctrl_q.pci;
   assign pcw    = ctrl_q.pcw;
   assign halted = ctrl_q.halted;

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_cpu_ctrl
//
// Table-driven check of stack_cpu_ctrl strobes per cycle, plus hand-written
// sequences for reset mid-instruction, CALL/RET with a small datapath model,
// and the sticky HALT state.
// -----------------------------------------------------------------------------
module tb_stack_cpu_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] instr_in;
   logic [15:0] ir;
   logic        regw;
   logic        memw;
   logic [1:0]  memin;
   logic        sflag;
   logic [1:0]  spi;
   logic        spw;
   logic        pcin;
   logic        pci;
   logic        pcw;
   logic        halted;

   stack_cpu_ctrl #(.IR_RESET(16'h0000)) dut (
      .clk      (clk),
      .reset    (reset),
      .instr_in (instr_in),
      .ir       (ir),
      .regw     (regw),
      .memw     (memw),
      .memin    (memin),
      .sflag    (sflag),
      .spi      (spi),
      .spw      (spw),
      .pcin     (pcin),
      .pci      (pci),
      .pcw      (pcw),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp;
   int n_fail;

   // {halted, regw, memw, memin, sflag, spi, spw, pcin, pci, pcw}
   logic [11:0] act;
   assign act = {halted, regw, memw, memin, sflag, spi, spw, pcin, pci, pcw};

   function automatic logic [11:0] ex(input logic regw_e, input logic memw_e,
                                      input logic [1:0] memin_e, input logic sflag_e,
                                      input logic [1:0] spi_e, input logic spw_e,
                                      input logic pcin_e, input logic pci_e,
                                      input logic pcw_e);
      return {1'b0, regw_e, memw_e, memin_e, sflag_e, spi_e, spw_e, pcin_e, pci_e, pcw_e};
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   // Minimal datapath model driven by the controller strobes.
   logic [15:0] pc_m;
   logic [15:0] sp_m;
   logic [15:0] mem_m [0:65535];
   logic [15:0] imm_m;
   assign imm_m = {{8{ir[7]}}, ir[7:0]};

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_m <= 16'd10;
         sp_m <= 16'd0;
      end else begin
         if (memw) mem_m[sp_m] <= (memin == 2'd0) ? 16'h1234 :
                                  (memin == 2'd1) ? pc_m : imm_m;
         if (spw) sp_m <= (spi == 2'd1) ? sp_m + 16'd1 :
                          (spi == 2'd2) ? sp_m - 16'd1 : sp_m;
         if (pcw) pc_m <= pcin ? (pci ? pc_m + 16'd1 + imm_m : pc_m + 16'd1)
                               : mem_m[sp_m];
      end
   end

   typedef struct {
      logic [15:0] instr;
      logic        three;
      logic [11:0] e1;
      logic [11:0] e2;
   } vec_t;

   vec_t vecs [10];

   // Entered at a negedge while in FETCH; leaves at the negedge back in FETCH.
   task automatic do_instr(input logic [15:0] instr, input logic three,
                           input logic [11:0] e1, input logic [11:0] e2);
      instr_in = instr;
      chk($sformatf("fetch_%h", instr), 32'(act), 32'(12'h000));
      @(negedge clk);
      instr_in = ~instr;
      chk($sformatf("ir_ex1_%h", instr), 32'(ir), 32'(instr));
      chk($sformatf("ex1_%h", instr), 32'(act), 32'(e1));
      if (three) begin
         @(negedge clk);
         chk($sformatf("ir_ex2_%h", instr), 32'(ir), 32'(instr));
         chk($sformatf("ex2_%h", instr), 32'(act), 32'(e2));
      end
      @(negedge clk);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b0;
      instr_in = 16'h0000;

      vecs[0] = '{16'h1200, 1'b0, ex(1,0,0,1,0,0,1,0,1), 12'h000};
      vecs[1] = '{16'h3800, 1'b0, ex(1,0,0,1,0,0,1,0,1), 12'h000};
      vecs[2] = '{16'h4045, 1'b1, ex(0,0,0,0,2,1,0,0,0), ex(0,1,2,0,0,0,1,0,1)};
      vecs[3] = '{16'h4003, 1'b1, ex(0,0,0,0,2,1,0,0,0), ex(0,1,0,0,0,0,1,0,1)};
      vecs[4] = '{16'h4820, 1'b0, ex(1,0,0,0,1,1,1,0,1), 12'h000};
      vecs[5] = '{16'h40E0, 1'b0, ex(0,0,0,0,0,0,1,0,1), 12'h000};
      vecs[6] = '{16'h9FFE, 1'b0, ex(0,0,0,0,0,0,1,1,1), 12'h000};
      vecs[7] = '{16'hC005, 1'b1, ex(0,0,0,0,2,1,0,0,0), ex(0,1,1,0,0,0,1,1,1)};
      vecs[8] = '{16'hD000, 1'b1, ex(0,0,0,0,0,0,0,0,1), ex(0,0,0,0,1,1,1,0,1)};
      vecs[9] = '{16'hF000, 1'b0, ex(0,0,0,0,0,0,1,0,1), 12'h000};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_ir", 32'(ir), 32'(16'h0000));
      chk("reset_strobes", 32'(act), 32'(12'h000));
      reset = 1'b1;

      for (int i = 0; i < 10; i++) begin
         do_instr(vecs[i].instr, vecs[i].three, vecs[i].e1, vecs[i].e2);
      end

      // Reset asserted during EX1 of CALL
      instr_in = 16'hC005;
      @(negedge clk);
      chk("midcall_ex1", 32'(act), 32'(ex(0,0,0,0,2,1,0,0,0)));
      reset = 1'b0;
      #1;
      chk("midcall_rst_strobes", 32'(act), 32'(12'h000));
      chk("midcall_rst_ir", 32'(ir), 32'(16'h0000));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midcall_memw_hold", 32'(memw), 32'(1'b0));
      end
      reset = 1'b1;
      instr_in = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("midcall_memw_after", 32'(memw), 32'(1'b0));
      end
      // Two edges after release: FETCH then EX1 of the ignored NOP-class word 0000.
      @(negedge clk);
      do_instr(16'h1200, 1'b0, ex(1,0,0,1,0,0,1,0,1), 12'h000);

      // CALL/RET through the datapath model, PC starts at 10, SP at 0
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      do_instr(16'hC005, 1'b1, ex(0,0,0,0,2,1,0,0,0), ex(0,1,1,0,0,0,1,1,1));
      chk("call_pc", 32'(pc_m), 32'(16'd16));
      chk("call_sp", 32'(sp_m), 32'(16'hFFFF));
      chk("call_mem", 32'(mem_m[16'hFFFF]), 32'(16'd10));
      do_instr(16'hD000, 1'b1, ex(0,0,0,0,0,0,0,0,1), ex(0,0,0,0,1,1,1,0,1));
      chk("ret_pc", 32'(pc_m), 32'(16'd11));
      chk("ret_sp", 32'(sp_m), 32'(16'h0000));
      do_instr(16'h4045, 1'b1, ex(0,0,0,0,2,1,0,0,0), ex(0,1,2,0,0,0,1,0,1));
      chk("pushimm_sp", 32'(sp_m), 32'(16'hFFFF));
      chk("pushimm_mem", 32'(mem_m[16'hFFFF]), 32'(16'h0045));
      chk("pushimm_pc", 32'(pc_m), 32'(16'd12));

      // HALT is sticky until reset
      instr_in = 16'hE000;
      @(negedge clk);
      chk("halt_ex1", 32'(act), 32'(12'h000));
      chk("halt_ex1_ir", 32'(ir), 32'(16'hE000));
      for (int i = 0; i < 20; i++) begin
         instr_in = 16'($urandom);
         @(negedge clk);
         chk("halt_sticky", 32'(act), 32'(12'h800));
         chk("halt_ir", 32'(ir), 32'(16'hE000));
      end
      reset = 1'b0;
      #1;
      chk("halt_cleared", 32'(act), 32'(12'h000));
      @(negedge clk);
      reset = 1'b1;
      do_instr(16'h9FFE, 1'b0, ex(0,0,0,0,0,0,1,1,1), 12'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
